// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_t;

  localparam int DATA_BITS_MIN = 5;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Collapse the two parity control inputs into one latched frame-config field.
  function automatic logic [1:0] parity_mode(input logic en, input logic odd);
    if (!en) return PAR_NONE;
    return odd ? PAR_ODD : PAR_EVEN;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Register-array TX FIFO with occupancy count, full/empty flags and an
// overflow pulse for writes dropped while full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: TX FIFO plus framing FSM with run-time
// data width (5..DATA_W_MAX), parity mode and stop-bit count.
// Optional feature: define UART_TX_BREAK_EN to add the send_break input,
// which forces the line low and holds the FSM idle once the frame completes.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W_MAX = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bit_tick,
  input  logic                  wr_en,
  input  logic [DATA_W_MAX-1:0] wr_data,
  input  logic [3:0]            data_bits,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                  send_break,
`endif
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  overflow
);

  tx_state_t             state;
  logic [DATA_W_MAX-1:0] shreg;
  logic [DATA_W_MAX-1:0] head;
  logic [3:0]            bit_cnt;
  logic [3:0]            cfg_bits;
  logic [1:0]            cfg_par;
  logic                  cfg_two_stop;
  logic                  acc;
  logic                  txd_q;
  logic                  pop;
  logic                  hold_idle;
  logic                  par_bit;

  // Clamp the requested word length into the supported range.
  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    if (b < 4'(DATA_BITS_MIN)) return 4'(DATA_BITS_MIN);
    if (b > 4'(DATA_W_MAX))    return 4'(DATA_W_MAX);
    return b;
  endfunction

`ifdef UART_TX_BREAK_EN
  assign hold_idle = send_break;
  assign txd       = txd_q & ~send_break;
  assign tx_busy   = (state != ST_IDLE) | send_break;
`else
  assign hold_idle = 1'b0;
  assign txd       = txd_q;
  assign tx_busy   = (state != ST_IDLE);
`endif

  // A new frame is only started on a bit boundary from IDLE.
  assign pop = bit_tick && (state == ST_IDLE) && !fifo_empty && !hold_idle;

  // Parity over all data bits including the one being sent on this tick.
  assign par_bit = acc ^ shreg[0] ^ (cfg_par == PAR_ODD);

  uart_tx_fifo #(
    .WIDTH (DATA_W_MAX),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_en),
    .pop      (pop),
    .wr_data  (wr_data),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (overflow)
  );

  // Framing FSM: state, frame config, shift register, parity and txd register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      txd_q        <= 1'b1;
      acc          <= 1'b0;
      bit_cnt      <= '0;
      cfg_bits     <= 4'(DATA_BITS_MIN);
      cfg_par      <= PAR_NONE;
      cfg_two_stop <= 1'b0;
    end else if (bit_tick) begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg        <= head;
            cfg_bits     <= clamp_bits(data_bits);
            cfg_par      <= parity_mode(parity_en, parity_odd);
            cfg_two_stop <= two_stop;
            bit_cnt      <= '0;
            acc          <= 1'b0;
            state        <= ST_START;
            txd_q        <= 1'b0;
          end else begin
            txd_q <= 1'b1;
          end
        end
        ST_START: begin
          state <= ST_DATA;
          txd_q <= shreg[0];
        end
        ST_DATA: begin
          acc     <= acc ^ shreg[0];
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == cfg_bits - 4'd1) begin
            if (cfg_par != PAR_NONE) begin
              state <= ST_PARITY;
              txd_q <= par_bit;
            end else begin
              state <= ST_STOP1;
              txd_q <= 1'b1;
            end
          end else begin
            shreg <= shreg >> 1;
            txd_q <= shreg[1];
          end
        end
        ST_PARITY: begin
          state <= ST_STOP1;
          txd_q <= 1'b1;
        end
        ST_STOP1: begin
          state <= cfg_two_stop ? ST_STOP2 : ST_IDLE;
          txd_q <= 1'b1;
        end
        ST_STOP2: begin
          state <= ST_IDLE;
          txd_q <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param (default build, DATA_W_MAX=9, FIFO_DEPTH=16).
module tb_uart_tx_param;

  localparam int DW  = 9;
  localparam int DEP = 16;
  localparam int CW  = $clog2(DEP) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bit_tick = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    data_bits = 4'd8;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          two_stop = 1'b0;
  logic          txd;
  logic          tx_busy;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_W_MAX (DW),
    .FIFO_DEPTH (DEP),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_tick   (bit_tick),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
`ifdef UART_TX_BREAK_EN
    .send_break (1'b0),
`endif
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // One bit period of 16 clocks, tick on the last one; sample 1 time unit after the edge.
  task automatic tick();
    repeat (15) @(negedge clk);
    bit_tick = 1'b1;
    @(posedge clk);
    #1 bit_tick = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] b, input logic pen, input logic podd, input logic ts);
    data_bits  = b;
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = ts;
  endtask

  // seq lists line bits in transmit order, first bit leftmost (bit n-1).
  task automatic run_frame(input string tag, input logic [15:0] seq, input int n, input bit perturb);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_bit%0d", tag, i), 32'(txd), 32'(seq[n-1-i]));
      check($sformatf("%s_busy%0d", tag, i), 32'(tx_busy), 32'd1);
      if (perturb && i == 0) set_cfg(4'd9, 1'b0, 1'b0, 1'b0);
    end
    tick();
    check({tag, "_idle_txd"}, 32'(txd), 32'd1);
    check({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
  endtask

  logic [7:0] words [3];
  logic       exp_bit;

  initial begin
    words[0] = 8'h3C;
    words[1] = 8'hA5;
    words[2] = 8'h0F;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 8N1 0x55
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    push(9'h055);
    check("push1_count", 32'(fifo_count), 32'd1);
    run_frame("f8n1", 16'b0101010101, 10, 1'b0);

    // 7E2 0x41 with config disturbed after the frame starts
    set_cfg(4'd7, 1'b1, 1'b0, 1'b1);
    push(9'h041);
    run_frame("f7e2", 16'b01000001011, 11, 1'b1);

    // 7O2 0x41
    set_cfg(4'd7, 1'b1, 1'b1, 1'b1);
    push(9'h041);
    run_frame("f7o2", 16'b01000001111, 11, 1'b0);

    // 9O1 0x1FF
    set_cfg(4'd9, 1'b1, 1'b1, 1'b0);
    push(9'h1FF);
    run_frame("f9o1", 16'b011111111101, 12, 1'b0);

    // 5N1 0xFF: upper bits ignored
    set_cfg(4'd5, 1'b0, 1'b0, 1'b0);
    push(9'h0FF);
    run_frame("f5n1", 16'b0111111, 7, 1'b0);

    // data_bits=3 clamps to 5: 0x0D -> 1,0,1,1,0
    set_cfg(4'd3, 1'b0, 1'b0, 1'b0);
    push(9'h00D);
    run_frame("fclamp", 16'b0101101, 7, 1'b0);

    // Back-to-back 8N1 frames with bit_tick held high
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) push({1'b0, words[k]});
    check("b2b_count3", 32'(fifo_count), 32'd3);
    @(negedge clk);
    bit_tick = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 11; b++) begin
        @(posedge clk);
        #1;
        if (b == 0)      exp_bit = 1'b0;
        else if (b <= 8) exp_bit = words[f][b-1];
        else             exp_bit = 1'b1;
        check($sformatf("b2b_f%0d_b%0d", f, b), 32'(txd), 32'(exp_bit));
        if (b == 0) check($sformatf("b2b_cnt_f%0d", f), 32'(fifo_count), 32'(2 - f));
        if (b == 10) check($sformatf("b2b_busy_f%0d", f), 32'(tx_busy), 32'd0);
      end
    end
    check("b2b_empty", 32'(fifo_empty), 32'd1);
    @(negedge clk);
    bit_tick = 1'b0;

    // Fill to full, then overflow on the 17th write
    for (int k = 0; k < DEP; k++) push(9'h000);
    check("fill_count", 32'(fifo_count), 32'd16);
    check("fill_full", 32'(fifo_full), 32'd1);
    check("fill_ovf0", 32'(overflow), 32'd0);
    push(9'h000);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd16);
    @(posedge clk);
    #1;
    check("ovf_clear", 32'(overflow), 32'd0);

    // Simultaneous pop and push while full
    @(negedge clk);
    wr_en    = 1'b1;
    wr_data  = 9'h000;
    bit_tick = 1'b1;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    bit_tick = 1'b0;
    check("fullpp_count", 32'(fifo_count), 32'd16);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    check("fullpp_start", 32'(txd), 32'd0);
    check("fullpp_busy", 32'(tx_busy), 32'd1);

    // Advance to DATA bit 3 and reset mid-frame
    repeat (4) tick();
    check("mid_txd", 32'(txd), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_txd", 32'(txd), 32'd1);
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_empty", 32'(fifo_empty), 32'd1);
    check("arst_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full frame after reset: 8N1 0xA5
    push(9'h0A5);
    run_frame("post_rst", 16'b0101001011, 10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
